chr_sram_arbiter: RTL and testbench
===================================

Name: chr_sram_arbiter

Overview:
- Owns the shared CHR SRAM once boot-time CHR loading completes.
- During boot, passes the CHR loader's SRAM pins straight through to the device.
- After the loader signals done, arbitrates byte-wide accesses between PPU pattern fetches (read) and CPU/mapper CHR-RAM accesses (read/write).
- Each access is a fixed-length SRAM cycle with a req/ack handshake; uses the plane-interleaved byte mapping of the loaded image.

Parameters:
ACC_CYCLES, 2, SRAM access length in i_clk cycles; legal range 2..15.

Ports:
i_clk  in  1  PPU clock
i_rstn  in  1  async active-low reset
i_ld_done  in  1  CHR loader finished
i_ld_addr  in  20  loader SRAM word address
i_ld_wdata  in  16  loader SRAM write data
i_ld_oe_n  in  1  loader output enable
i_ld_we_n  in  1  loader write enable
i_ld_ub_n  in  1  loader upper-byte enable
i_ld_lb_n  in  1  loader lower-byte enable
i_ppu_req  in  1  PPU read request, level, held until ack
i_ppu_addr  in  20  PPU CHR byte address, bank-extended
o_ppu_ack  out  1  one-cycle pulse; o_ppu_rdata valid in the same cycle
o_ppu_rdata  out  8  PPU read byte
i_cpu_req  in  1  CPU request, level, held until ack
i_cpu_we  in  1  1 = write, 0 = read
i_cpu_addr  in  20  CPU CHR byte address
i_cpu_wdata  in  8  CPU write byte
o_cpu_ack  out  1  one-cycle pulse
o_cpu_rdata  out  8  CPU read byte
o_sram_addr  out  20  SRAM word address
o_sram_wdata  out  16  SRAM write data
i_sram_rdata  in  16  SRAM read data
o_sram_oe_n  out  1  SRAM output enable
o_sram_we_n  out  1  SRAM write enable
o_sram_ub_n  out  1  SRAM upper-byte enable
o_sram_lb_n  out  1  SRAM lower-byte enable

Behaviour:
- Reset is asynchronous and active-low on i_rstn; the clock is i_clk.
- Reset values: state BOOT, acks 0, rdata 0, grant-history flag = CPU (so PPU wins the first tie), cycle counter 0, internal SRAM registers addr 0, wdata 0, oe_n/we_n/ub_n/lb_n 1.
- Byte mapping for byte address A:
  - word address = {1'b0, A[19:4], A[2:0]}
  - A[3]=1 selects the upper lane (ub_n=0); A[3]=0 selects the lower lane (lb_n=0).
  - Read byte = A[3] ? i_sram_rdata[15:8] : i_sram_rdata[7:0].
  - Write data is replicated to both lanes.
- States: BOOT, IDLE, ACC.
- BOOT:
  - All o_sram_* are combinational copies of the i_ld_* inputs. Acks stay 0; requests are left pending.
  - i_ld_done=1 sampled -> IDLE. i_ld_done is treated as sticky; a later drop is ignored.
- IDLE:
  - SRAM registers hold addr; oe_n, we_n, ub_n, lb_n = 1.
  - No grant is made in any cycle where o_ppu_ack or o_cpu_ack is high. This lets the requester deassert req first.
  - Otherwise, if any req is high: latch the winner's addr, lane, we and wdata; counter=0; -> ACC.
  - Tie rule: PPU wins unless the last grant was PPU; then CPU wins (strict alternation under contention). A lone requester always wins.
  - Request inputs are sampled only at the grant edge; later changes are ignored until ack.
- ACC read:
  - oe_n=0 and the selected lane enable=0 for the entire access; we_n=1.
- ACC write:
  - oe_n=1; lane enable=0 for the entire access.
  - we_n=0 for counter values 0..ACC_CYCLES-2, and we_n=1 in the last cycle (address/data hold).
- ACC advance: counter increments each cycle. At the edge where counter==ACC_CYCLES-1:
  - capture the read byte into the winner's rdata (writes leave rdata unchanged)
  - set the winner's ack=1 for one cycle
  - update the grant-history flag
  - -> IDLE
- Latency: req high at grant edge E0 -> ack high in the cycle following edge E0+ACC_CYCLES. Minimum request-to-request spacing is ACC_CYCLES+2 cycles.
- Only one access is outstanding at a time. PPU and CPU acks never assert together.
- Reset mid-access: the access is aborted, no ack is issued, the block returns to BOOT and SRAM control follows the loader. The loader shares i_rstn.

Test Plan:
1. Boot passthrough: before done, drive i_ld_addr=0x00123, we_n=0, ub_n=0, wdata=0xBEEF -> o_sram_* equal the inputs in the same cycle. Hold i_ppu_req=1 -> o_ppu_ack stays 0 until i_ld_done, then acks.
2. PPU read: i_ppu_addr=0x00008, SRAM word 0 = 0xA55A -> o_sram_addr=0x00000, ub_n=0, lb_n=1, oe_n=0 for 2 cycles. o_ppu_ack pulses 1 cycle with o_ppu_rdata=0xA5, 2 cycles after the grant edge.
3. CPU write: i_cpu_addr=0x01234, wdata=0x3C -> o_sram_addr=0x0091C, lb_n=0, ub_n=1, wdata=0x3C3C, we_n low exactly 1 cycle then high 1 cycle, oe_n=1, o_cpu_ack pulse.
4. Contention: both req held continuously after done -> grant order PPU, CPU, PPU, CPU. Each ack is separated by 4 cycles (ACC_CYCLES=2); no back-to-back acks.
5. CPU read of 0x01234 after test 3 -> o_cpu_rdata=0x3C. Ack-cycle rule: re-asserting req in the ack cycle is not granted until the following cycle.
6. Reset mid-ACC: assert i_rstn=0 at counter=0 of a write -> acks 0, we_n follows the loader immediately. After release, the block sits in BOOT until i_ld_done.

Source files
------------

// File: rtl/chr_sram_arbiter.sv
// CHR SRAM owner: loader passthrough during boot, then fixed-length byte accesses
// arbitrated between PPU pattern reads and CPU CHR-RAM reads/writes.
module chr_sram_arbiter #(
    parameter int ACC_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_ld_done,
    input  logic [19:0] i_ld_addr,
    input  logic [15:0] i_ld_wdata,
    input  logic        i_ld_oe_n,
    input  logic        i_ld_we_n,
    input  logic        i_ld_ub_n,
    input  logic        i_ld_lb_n,
    input  logic        i_ppu_req,
    input  logic [19:0] i_ppu_addr,
    output logic        o_ppu_ack,
    output logic [7:0]  o_ppu_rdata,
    input  logic        i_cpu_req,
    input  logic        i_cpu_we,
    input  logic [19:0] i_cpu_addr,
    input  logic [7:0]  i_cpu_wdata,
    output logic        o_cpu_ack,
    output logic [7:0]  o_cpu_rdata,
    output logic [19:0] o_sram_addr,
    output logic [15:0] o_sram_wdata,
    input  logic [15:0] i_sram_rdata,
    output logic        o_sram_oe_n,
    output logic        o_sram_we_n,
    output logic        o_sram_ub_n,
    output logic        o_sram_lb_n
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_ACC  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACC_CYCLES - 1);
    localparam logic [3:0] PRE_LAST_CNT = 4'(ACC_CYCLES - 2);

    // Image is plane-interleaved: byte address bit 3 picks the 16-bit lane.
    function automatic logic [19:0] word_addr(input logic [19:0] a);
        return {1'b0, a[19:4], a[2:0]};
    endfunction

    function automatic logic [7:0] lane_byte(input logic [15:0] d, input logic upper);
        return upper ? d[15:8] : d[7:0];
    endfunction

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic        last_ppu_r;
    logic        cur_cpu_r;
    logic        cur_upper_r;
    logic [19:0] sram_addr_r;
    logic [15:0] sram_wdata_r;
    logic        sram_oe_n_r;
    logic        sram_we_n_r;
    logic        sram_ub_n_r;
    logic        sram_lb_n_r;
    logic        ppu_ack_r;
    logic        cpu_ack_r;
    logic [7:0]  ppu_rdata_r;
    logic [7:0]  cpu_rdata_r;

    logic        gnt_ppu_s;
    logic        gnt_any_s;
    logic [19:0] gnt_addr_s;
    logic        gnt_we_s;
    logic        boot_s;

    // Arbitration: PPU wins a tie unless it had the previous grant.
    always_comb begin
        gnt_ppu_s  = 1'b0;
        gnt_addr_s = 20'd0;
        gnt_we_s   = 1'b0;
        gnt_any_s  = i_ppu_req | i_cpu_req;
        if (i_ppu_req && (!i_cpu_req || !last_ppu_r)) begin
            gnt_ppu_s  = 1'b1;
            gnt_addr_s = i_ppu_addr;
            gnt_we_s   = 1'b0;
        end else begin
            gnt_ppu_s  = 1'b0;
            gnt_addr_s = i_cpu_addr;
            gnt_we_s   = i_cpu_we;
        end
    end

    // Boot/idle/access sequencer with registered SRAM controls and acks.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r      <= ST_BOOT;
            cnt_r        <= 4'd0;
            last_ppu_r   <= 1'b0;
            cur_cpu_r    <= 1'b0;
            cur_upper_r  <= 1'b0;
            sram_addr_r  <= 20'd0;
            sram_wdata_r <= 16'd0;
            sram_oe_n_r  <= 1'b1;
            sram_we_n_r  <= 1'b1;
            sram_ub_n_r  <= 1'b1;
            sram_lb_n_r  <= 1'b1;
            ppu_ack_r    <= 1'b0;
            cpu_ack_r    <= 1'b0;
            ppu_rdata_r  <= 8'd0;
            cpu_rdata_r  <= 8'd0;
        end else begin
            ppu_ack_r <= 1'b0;
            cpu_ack_r <= 1'b0;
            case (state_r)
                ST_BOOT: begin
                    if (i_ld_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_BOOT;
                    end
                end
                ST_IDLE: begin
                    sram_oe_n_r <= 1'b1;
                    sram_we_n_r <= 1'b1;
                    sram_ub_n_r <= 1'b1;
                    sram_lb_n_r <= 1'b1;
                    // Skip the ack cycle so the requester can drop req first.
                    if (!ppu_ack_r && !cpu_ack_r && gnt_any_s) begin
                        state_r     <= ST_ACC;
                        cnt_r       <= 4'd0;
                        cur_cpu_r   <= !gnt_ppu_s;
                        cur_upper_r <= gnt_addr_s[3];
                        sram_addr_r <= word_addr(gnt_addr_s);
                        sram_oe_n_r <= gnt_we_s;
                        sram_we_n_r <= !gnt_we_s;
                        sram_ub_n_r <= !gnt_addr_s[3];
                        sram_lb_n_r <= gnt_addr_s[3];
                        if (!gnt_ppu_s) begin
                            sram_wdata_r <= {i_cpu_wdata, i_cpu_wdata};
                        end else begin
                            sram_wdata_r <= sram_wdata_r;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACC: begin
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == LAST_CNT) begin
                        state_r     <= ST_IDLE;
                        cnt_r       <= 4'd0;
                        last_ppu_r  <= !cur_cpu_r;
                        sram_oe_n_r <= 1'b1;
                        sram_we_n_r <= 1'b1;
                        sram_ub_n_r <= 1'b1;
                        sram_lb_n_r <= 1'b1;
                        if (cur_cpu_r) begin
                            cpu_ack_r <= 1'b1;
                            if (sram_oe_n_r == 1'b0) begin
                                cpu_rdata_r <= lane_byte(i_sram_rdata, cur_upper_r);
                            end else begin
                                cpu_rdata_r <= cpu_rdata_r;
                            end
                        end else begin
                            ppu_ack_r   <= 1'b1;
                            ppu_rdata_r <= lane_byte(i_sram_rdata, cur_upper_r);
                        end
                    end else if (cnt_r == PRE_LAST_CNT) begin
                        // Last cycle of a write holds address/data with we_n released.
                        sram_we_n_r <= 1'b1;
                    end else begin
                        sram_we_n_r <= sram_we_n_r;
                    end
                end
                default: begin
                    state_r <= ST_BOOT;
                end
            endcase
        end
    end

    assign boot_s       = (state_r == ST_BOOT);
    assign o_sram_addr  = boot_s ? i_ld_addr  : sram_addr_r;
    assign o_sram_wdata = boot_s ? i_ld_wdata : sram_wdata_r;
    assign o_sram_oe_n  = boot_s ? i_ld_oe_n  : sram_oe_n_r;
    assign o_sram_we_n  = boot_s ? i_ld_we_n  : sram_we_n_r;
    assign o_sram_ub_n  = boot_s ? i_ld_ub_n  : sram_ub_n_r;
    assign o_sram_lb_n  = boot_s ? i_ld_lb_n  : sram_lb_n_r;
    assign o_ppu_ack    = ppu_ack_r;
    assign o_cpu_ack    = cpu_ack_r;
    assign o_ppu_rdata  = ppu_rdata_r;
    assign o_cpu_rdata  = cpu_rdata_r;

endmodule

// File: tb/tb_chr_sram_arbiter.sv
// Directed bench for chr_sram_arbiter: SRAM model, ack scoreboard, pin checks.
module tb_chr_sram_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ld_done = 1'b0;
    logic [19:0] ld_addr = 20'd0;
    logic [15:0] ld_wdata = 16'd0;
    logic        ld_oe_n = 1'b1, ld_we_n = 1'b1, ld_ub_n = 1'b1, ld_lb_n = 1'b1;
    logic        ppu_req = 1'b0;
    logic [19:0] ppu_addr = 20'd0;
    logic        ppu_ack;
    logic [7:0]  ppu_rdata;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [19:0] cpu_addr = 20'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [19:0] sram_addr;
    logic [15:0] sram_wdata, sram_rdata;
    logic        sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int cmp_cnt = 0;
    int fail_cnt = 0;

    typedef struct packed { logic is_cpu; logic [7:0] rd; } exp_t;
    exp_t sb[$];

    logic [15:0] mem [0:4095];

    chr_sram_arbiter #(.ACC_CYCLES(2)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_ld_done(ld_done),
        .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata), .i_ld_oe_n(ld_oe_n),
        .i_ld_we_n(ld_we_n), .i_ld_ub_n(ld_ub_n), .i_ld_lb_n(ld_lb_n),
        .i_ppu_req(ppu_req), .i_ppu_addr(ppu_addr), .o_ppu_ack(ppu_ack),
        .o_ppu_rdata(ppu_rdata), .i_cpu_req(cpu_req), .i_cpu_we(cpu_we),
        .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata), .o_cpu_ack(cpu_ack),
        .o_cpu_rdata(cpu_rdata), .o_sram_addr(sram_addr), .o_sram_wdata(sram_wdata),
        .i_sram_rdata(sram_rdata), .o_sram_oe_n(sram_oe_n), .o_sram_we_n(sram_we_n),
        .o_sram_ub_n(sram_ub_n), .o_sram_lb_n(sram_lb_n)
    );

    always #5 clk = ~clk;

    // Asynchronous-read, synchronous-write byte-lane SRAM model.
    assign sram_rdata = mem[sram_addr[11:0]];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            if (!sram_ub_n) mem[sram_addr[11:0]][15:8] <= sram_wdata[15:8];
            if (!sram_lb_n) mem[sram_addr[11:0]][7:0]  <= sram_wdata[7:0];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack pops and checks the oldest expected response.
    always @(negedge clk) begin
        if (rstn) begin
            if (ppu_ack && cpu_ack) chk("dual_ack", 32'd1, 32'd0);
            if (ppu_ack || cpu_ack) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_owner", {31'd0, cpu_ack}, {31'd0, e.is_cpu});
                    chk("ack_rdata", {24'd0, cpu_ack ? cpu_rdata : ppu_rdata}, {24'd0, e.rd});
                end
            end
        end
    end

    // One access: raise req, wait for the grant, check pin shape and ack timing.
    task automatic access(input bit is_cpu, input bit we, input logic [19:0] addr,
                          input logic [7:0] wd, input logic [19:0] exp_waddr,
                          input bit upper, input int max_wait, input bit hold_req);
        bit got;
        got = 1'b0;
        if (is_cpu) begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        end else begin
            ppu_req = 1'b1; ppu_addr = addr;
        end
        for (int i = 0; i < max_wait; i++) begin
            @(negedge clk);
            if (!(sram_ub_n && sram_lb_n)) begin
                got = 1'b1;
                break;
            end
        end
        chk("grant_seen", {31'd0, got}, 32'd1);
        if (got) begin
            for (int c = 0; c < 2; c++) begin
                chk("acc_addr", {12'd0, sram_addr}, {12'd0, exp_waddr});
                chk("acc_oe_n", {31'd0, sram_oe_n}, {31'd0, we});
                chk("acc_we_n", {31'd0, sram_we_n}, (we && c == 0) ? 32'd0 : 32'd1);
                chk("acc_ub_n", {31'd0, sram_ub_n}, {31'd0, !upper});
                chk("acc_lb_n", {31'd0, sram_lb_n}, {31'd0, upper});
                if (we) chk("acc_wdata", {16'd0, sram_wdata}, {16'd0, wd, wd});
                chk("ack_early", {31'd0, is_cpu ? cpu_ack : ppu_ack}, 32'd0);
                @(negedge clk);
            end
            chk("ack_pulse", {31'd0, is_cpu ? cpu_ack : ppu_ack}, 32'd1);
            chk("post_oe_n", {31'd0, sram_oe_n}, 32'd1);
        end
        if (!hold_req) begin
            if (is_cpu) cpu_req = 1'b0; else ppu_req = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n, prev_cyc;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ppu_ack", {31'd0, ppu_ack}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_ppu_rdata", {24'd0, ppu_rdata}, 32'd0);
        chk("rst_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
        rstn = 1'b1;

        // Test 1: boot passthrough, loader also plants word 0 = 0xA55A
        @(negedge clk);
        ld_addr = 20'h00123; ld_wdata = 16'hBEEF; ld_we_n = 1'b0; ld_ub_n = 1'b0;
        #1;
        chk("pt_addr", {12'd0, sram_addr}, 32'h00123);
        chk("pt_wdata", {16'd0, sram_wdata}, 32'hBEEF);
        chk("pt_we_n", {31'd0, sram_we_n}, 32'd0);
        chk("pt_ub_n", {31'd0, sram_ub_n}, 32'd0);
        chk("pt_lb_n", {31'd0, sram_lb_n}, 32'd1);
        chk("pt_oe_n", {31'd0, sram_oe_n}, 32'd1);
        @(negedge clk);
        ld_addr = 20'h00000; ld_wdata = 16'hA55A; ld_lb_n = 1'b0;
        @(negedge clk);
        ld_we_n = 1'b1; ld_ub_n = 1'b1; ld_lb_n = 1'b1;
        ppu_req = 1'b1; ppu_addr = 20'h00008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("boot_no_ack", {31'd0, ppu_ack}, 32'd0);
        end
        sb.push_back('{is_cpu: 1'b0, rd: 8'hA5});
        ld_done = 1'b1;

        // Test 2: PPU read of upper lane at word 0
        access(1'b0, 1'b0, 20'h00008, 8'h00, 20'h00000, 1'b1, 6, 1'b0);
        ld_done = 1'b0;

        // Test 3: CPU write to lower lane
        sb.push_back('{is_cpu: 1'b1, rd: 8'h00});
        access(1'b1, 1'b1, 20'h01234, 8'h3C, 20'h0091C, 1'b0, 6, 1'b0);
        chk("mem_write", {16'd0, mem[12'h91C]}, 32'h003C);

        // Test 4: sustained contention alternates PPU/CPU, one ack per 4 cycles
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{is_cpu: 1'b0, rd: 8'hA5});
            sb.push_back('{is_cpu: 1'b1, rd: 8'h3C});
        end
        ppu_req = 1'b1; ppu_addr = 20'h00008;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'h01234;
        n = 0; prev_cyc = -1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ppu_ack || cpu_ack) begin
                chk("cont_order", {31'd0, cpu_ack}, (n % 2 == 1) ? 32'd1 : 32'd0);
                if (prev_cyc >= 0) chk("cont_spacing", cyc - prev_cyc, 32'd4);
                prev_cyc = cyc;
                n++;
                if (n == 4) begin
                    ppu_req = 1'b0; cpu_req = 1'b0;
                    break;
                end
            end
        end
        chk("cont_acks", n, 32'd4);
        ppu_req = 1'b0; cpu_req = 1'b0;

        // Test 5: CPU read-back; req held through ack is re-granted one cycle later
        @(negedge clk);
        sb.push_back('{is_cpu: 1'b1, rd: 8'h3C});
        sb.push_back('{is_cpu: 1'b1, rd: 8'h3C});
        access(1'b1, 1'b0, 20'h01234, 8'h00, 20'h0091C, 1'b0, 6, 1'b1);
        @(negedge clk);
        chk("ackcyc_no_grant", {31'd0, sram_lb_n}, 32'd1);
        access(1'b1, 1'b0, 20'h01234, 8'h00, 20'h0091C, 1'b0, 1, 1'b0);

        // Test 6: reset in the first cycle of a write aborts it
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00010; cpu_wdata = 8'h77;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!sram_we_n) begin
                n = 1;
                break;
            end
        end
        chk("rst_wr_started", n, 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_cpu_ack2", {31'd0, cpu_ack}, 32'd0);
        chk("rst_ppu_rdata2", {24'd0, ppu_rdata}, 32'd0);
        cpu_req = 1'b0;
        ld_addr = 20'h00123; ld_we_n = 1'b0;
        #1;
        chk("rst_follow_we", {31'd0, sram_we_n}, 32'd0);
        chk("rst_follow_addr", {12'd0, sram_addr}, 32'h00123);
        ld_we_n = 1'b1;
        @(negedge clk);
        rstn = 1'b1;
        ppu_req = 1'b1; ppu_addr = 20'h00008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("reboot_no_ack", {31'd0, ppu_ack}, 32'd0);
            chk("reboot_pt_oe", {31'd0, sram_oe_n}, 32'd1);
        end
        chk("aborted_write", {16'd0, mem[12'h008]}, 32'h0000);
        sb.push_back('{is_cpu: 1'b0, rd: 8'hA5});
        ld_done = 1'b1;
        access(1'b0, 1'b0, 20'h00008, 8'h00, 20'h00000, 1'b1, 6, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
